// File: rtl/sev_seg_pkg.sv
// Shared constants and types for the seven-segment display path: digit count,
// special nibble codes, display range limit and the BCD formatter state type.
package sev_seg_pkg;

  localparam int unsigned NDIG = 8;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  localparam logic [26:0] MAX_DISP = 27'd99_999_999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } fmt_state_e;

  // Leading zeros become BLANK_CODE down to the first non-zero digit; digit 0 always shows.
  function automatic logic [4*NDIG-1:0] blank_leading(input logic [4*NDIG-1:0] bcd);
    logic [4*NDIG-1:0] res;
    logic              lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Double-dabble correction: every BCD nibble >= 5 gets +3, nibbles independent,
// no carry between digits.
module bcd_dabble_step
  import sev_seg_pkg::*;
#(
  parameter int unsigned DIGITS = sev_seg_pkg::NDIG
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic [4*DIGITS-1:0] corrected
);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] nib;
    assign nib = bcd[4*g +: 4];
    assign corrected[4*g +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

endmodule

// File: rtl/sev_seg_bcd_formatter.sv
// Iterative binary-to-BCD formatter feeding the seven-segment driver: one
// double-dabble shift per clock, then optional leading-zero blanking.
module sev_seg_bcd_formatter
  import sev_seg_pkg::*;
#(
  parameter int unsigned BIN_W = 27,
  parameter int unsigned NDIG  = sev_seg_pkg::NDIG
) (
  input  logic                sclk_1ms,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                load,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [4*NDIG-1:0]   data_out
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  fmt_state_e        state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lz_q, lz_d;
  logic              ovf_q, ovf_d;
  logic [4*NDIG-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [4*NDIG-1:0] bcd_adj;

  bcd_dabble_step #(
    .DIGITS (NDIG)
  ) u_step (
    .bcd       (bcd_q),
    .corrected (bcd_adj)
  );

  always_ff @(posedge sclk_1ms or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      lz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      lz_q       <= lz_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    lz_d       = lz_q;
    ovf_d      = ovf_q;
    data_d     = data_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          bin_d = bin_in;
          bcd_d = '0;
          cnt_d = CNT_W'(BIN_W);
          lz_d  = blank_lz;
          ovf_d = (bin_in > BIN_W'(MAX_DISP));
          // Out-of-range values skip the conversion and go straight to the error pattern.
          state_d = ovf_d ? FORMAT : SHIFT;
        end
      end

      SHIFT: begin
        bcd_d = {bcd_adj[4*NDIG-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FORMAT;
        end
      end

      FORMAT: begin
        if (ovf_q) begin
          data_d = {NDIG{ERR_CODE}};
        end else if (lz_q) begin
          data_d = blank_leading(bcd_q);
        end else begin
          data_d = bcd_q;
        end
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign data_out = data_q;

endmodule

// File: doc/sev_seg_bcd_formatter.md
Name: sev_seg_bcd_formatter

Overview:
Sequential binary-to-BCD formatter that sits directly upstream of the seven-segment display driver and produces its 32-bit packed 8-digit data word. It accepts a binary amount (account balance, entered value) on a load strobe and converts it iteratively using shift-and-add-3 (double dabble), one bit per clock. It then applies optional leading-zero blanking and holds the result stable until the next conversion. It runs on the 1 ms display clock, so conversion latency (tens of ms) is invisible to the user.

Parameters:
BIN_W, 27, binary input width; 2^27 > 99_999_999, so 8 digits suffice.
NDIG, 8, number of BCD digits in data_out; fixed at 8 to match the display.

Ports:
sclk_1ms  input  1  clock, 1 kHz divided clock from the display clock divider
rst  input  1  reset, asynchronous, active-high
bin_in  input  BIN_W  unsigned binary value to format
load  input  1  start request; sampled only in IDLE
blank_lz  input  1  1 = replace leading zeros with blank code; sampled with load
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when data_out updates
overflow  output  1  high if the last loaded value exceeded 99_999_999
data_out  output  32  packed BCD to display data_in; digit 0 = [3:0] (rightmost)

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, overflow=0, data_out=32'h0000_0000, shift/count registers=0.
- States: IDLE, SHIFT, FORMAT.
- IDLE, load=1 at edge E0:
  - Capture bin_in into the shift register and blank_lz into lz_q.
  - Clear the BCD accumulator and set bit counter=BIN_W.
  - If bin_in > 99_999_999, set ovf_q=1 and go to FORMAT; otherwise go to SHIFT.
  - busy=1 from E0.
- SHIFT: at each edge:
  - Every BCD digit >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1 and the counter decrements.
  - When the counter reaches 1 on this edge (the final shift), go to FORMAT.
  - Exactly BIN_W shift edges: E1..E27.
- FORMAT, one edge (E28 normal; E1 for overflow):
  - If ovf_q: data_out=32'hEEEE_EEEE, overflow=1.
  - Else: data_out=BCD with blanking, overflow=0.
  - done=1 for that cycle, busy=0, next state IDLE.
- Blanking, lz_q=1: scan from digit 7 downward; each 0 digit becomes 4'hF until the first non-zero digit. Digit 0 is never blanked. Interior zeros are kept.
- Codes: 4'hF = all segments off; 4'hE = 'E'. The display decoder honours both.
- data_out holds its previous value throughout SHIFT, so there is no flicker or partial results.
- load while busy: ignored, no queueing. load in the same cycle as done (FORMAT): ignored; it is accepted the next cycle if still high.
- load held high continuously: re-converts back-to-back. One done per 29 cycles (2 for overflow).
- rst mid-conversion: immediate return to reset values. data_out clears to 0 and no done is issued.
- Arithmetic: add-3 is per nibble, 4-bit, no carry between digits. The overflow compare is unsigned, BIN_W bits.

Decomposition:
- Shared package sev_seg_pkg:
  - BLANK_CODE=4'hF, ERR_CODE=4'hE, MAX_DISP=27'd99_999_999.
  - State typedef {IDLE, SHIFT, FORMAT}.
  - NDIG constant, shared with the display driver.
- One natural sub-module, bcd_dabble_step: combinational, 32-bit BCD in, 32-bit corrected BCD out (8 parallel add-3 nibble correctors). Instantiated once in the SHIFT datapath.

Test Plan:
- Reset, then load bin_in=1234 with blank_lz=1 -> busy for 28 cycles; at E28 done=1, data_out=32'hFFFF_1234, overflow=0.
- bin_in=0, blank_lz=1 -> data_out=32'hFFFF_FFF0. Same value with blank_lz=0 -> 32'h0000_0000 (done still pulses).
- bin_in=10203, blank_lz=1 -> 32'hFFF1_0203 (interior zeros kept). bin_in=99_999_999 -> 32'h9999_9999.
- bin_in=100_000_000 -> done at E1, data_out=32'hEEEE_EEEE, overflow=1. Next load of 5 -> 32'hFFFF_FFF5, overflow=0.
- Load 42, then pulse load with 77 at E10 -> ignored; result 32'hFFFF_FF42. data_out holds the prior value until E28.
- Assert rst at E15 of a conversion -> data_out=0, busy=0 immediately, no done. A fresh load of 8 converts normally.
